// File: rtl/seven_seg_scan_driver.sv
// Eight-digit common-anode 7-segment scan driver with frame-coherent shadow capture,
// per-digit enable/DP, leading-zero blanking and an anti-ghost blank window per slot.
module seven_seg_scan_driver #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned DIGIT_HZ     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [31:0] value_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [7:0]  AN,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic        frame_start
);

  localparam int unsigned DIV = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_val_s;
  logic [7:0]    r_dp_s;
  logic [7:0]    r_en_s;
  logic          r_lz_s;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_fs;

  logic          w_frame;
  logic [3:0]    w_nib;
  logic [7:0]    w_upper_zero;
  logic          w_lit;
  logic [6:0]    w_glyph;

  assign w_frame = (r_cnt == '0) && (r_idx == '0);
  assign w_nib   = r_val_s[{r_idx, 2'b00} +: 4];

  // w_upper_zero[k]: nibbles k..7 of the captured value are all zero
  always_comb begin
    w_upper_zero = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_upper_zero[i] = ((r_val_s >> (4 * i)) == '0);
    end
  end

  assign w_lit = r_en_s[r_idx] && (r_cnt >= BLANK) &&
                 !(r_lz_s && (r_idx != '0) && w_upper_zero[r_idx]);

  // Active-low {a,b,c,d,e,f,g}
  always_comb begin
    w_glyph = '1;
    case (w_nib)
      4'h0: w_glyph = 7'b0000001;
      4'h1: w_glyph = 7'b1001111;
      4'h2: w_glyph = 7'b0010010;
      4'h3: w_glyph = 7'b0000110;
      4'h4: w_glyph = 7'b1001100;
      4'h5: w_glyph = 7'b0100100;
      4'h6: w_glyph = 7'b0100000;
      4'h7: w_glyph = 7'b0001111;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0001100;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b1100000;
      4'hC: w_glyph = 7'b1110010;
      4'hD: w_glyph = 7'b1000010;
      4'hE: w_glyph = 7'b0110000;
      4'hF: w_glyph = 7'b0111000;
      default: w_glyph = '1;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_val_s <= '0;
      r_dp_s  <= '0;
      r_en_s  <= '0;
      r_lz_s  <= 1'b0;
      r_an    <= '1;
      r_seg   <= '1;
      r_dp    <= 1'b1;
      r_fs    <= 1'b0;
    end else begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_frame) begin
        r_val_s <= value_in;
        r_dp_s  <= dp_in;
        r_en_s  <= digit_en;
        r_lz_s  <= lz_blank;
      end
      r_fs <= w_frame;

      // Outputs reflect the slot position one cycle earlier, giving a fixed 1-cycle latency
      if (w_lit) begin
        r_an  <= ~(8'b1 << r_idx);
        r_seg <= w_glyph;
        r_dp  <= ~r_dp_s[r_idx];
      end else begin
        r_an  <= '1;
        r_seg <= '1;
        r_dp  <= 1'b1;
      end
    end
  end

  assign AN                       = r_an;
  assign {CA, CB, CC, CD, CE, CF, CG} = r_seg;
  assign DP                       = r_dp;
  assign frame_start              = r_fs;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: a cycle-count reference model pushes expected
// outputs per clock; a negedge monitor pops and compares them against the display pins.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = '0;
  logic        lz_blank = 1'b0;
  logic [7:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG, DP, frame_start;
  logic [6:0]  seg;

  assign seg = {CA, CB, CC, CD, CE, CF, CG};

  seven_seg_scan_driver #(
    .CLK_HZ      (1000),
    .DIGIT_HZ    (100),
    .BLANK_CYCLES(2)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .AN         (AN),
    .CA         (CA),
    .CB         (CB),
    .CC         (CC),
    .CD         (CD),
    .CE         (CE),
    .CF         (CF),
    .CG         (CG),
    .DP         (DP),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pop    = 0;
  int   e        = 0;   // posedges since reset release

  string GLYPHS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcfg", "abcefg", "cdefg", "deg", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input int n);
    logic [6:0] m;
    int         k;
    m = 7'h7F;
    for (int i = 0; i < GLYPHS[n].len(); i++) begin
      k = int'(GLYPHS[n][i]) - 97;
      m[6 - k] = 1'b0;
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the 80-cycle scan is derived purely from the cycle count
  logic [31:0] f_val;
  logic [7:0]  f_dp, f_en;
  logic        f_lz;
  int          m_s, m_pos, m_d;
  bit          m_lit;
  exp_t        m_x;

  always @(posedge clk) begin
    if (!rst_n) begin
      e = 0;
    end else begin
      e++;
      if (e % 80 == 1) begin
        f_val = value_in;
        f_dp  = dp_in;
        f_en  = digit_en;
        f_lz  = lz_blank;
      end
      m_s   = e - 1;
      m_pos = m_s % 10;
      m_d   = (m_s / 10) % 8;
      m_lit = (e > 1) && f_en[m_d] && (m_pos >= 2) &&
              !(f_lz && (m_d != 0) && ((f_val >> (4 * m_d)) == 0));
      m_x.an  = m_lit ? (8'hFF ^ (8'd1 << m_d)) : 8'hFF;
      m_x.seg = m_lit ? glyph(int'((f_val >> (4 * m_d)) & 32'hF)) : 7'h7F;
      m_x.dp  = m_lit ? ~f_dp[m_d] : 1'b1;
      m_x.fs  = (e % 80 == 1);
      q.push_back(m_x);
    end
  end

  int   cyc = 0;
  int   last_fs = -1;
  exp_t got;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      last_fs = -1;
      check("rst_AN", AN, 8'hFF);
      check("rst_SEG", seg, 7'h7F);
      check("rst_DP", DP, 1'b1);
      check("rst_FS", frame_start, 1'b0);
    end else if (q.size() > 0) begin
      got = q.pop_front();
      n_pop++;
      check("sb_AN", AN, got.an);
      check("sb_SEG", seg, got.seg);
      check("sb_DP", DP, got.dp);
      check("sb_FS", frame_start, got.fs);
      if (frame_start) begin
        if (last_fs >= 0) check("fs_period", cyc - last_fs, 80);
        last_fs = cyc;
      end
    end
  end

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  task automatic wait_e(input int target);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(rst_n && e == target) && g < 400);
    if (g >= 400) timeout("wait_e");
  endtask

  task automatic wait_pos(input int p);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(rst_n && e > 0 && (e % 80) == p) && g < 400);
    if (g >= 400) timeout("wait_pos");
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_AN", AN, 8'hFF);
    check("arst_SEG", seg, 7'h7F);
    check("arst_DP", DP, 1'b1);
    check("arst_FS", frame_start, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          sh;

    value_in = 32'h7654_3210; digit_en = 8'hFF; dp_in = 8'h00; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_e(1);  check("t1_fs_first", frame_start, 1'b1);
    wait_e(2);  check("t1_blank_AN", AN, 8'hFF);
                check("t1_fs_once", frame_start, 1'b0);
    wait_e(3);  check("t1_d0_AN", AN, 8'hFE);
                check("t1_d0_SEG", seg, 7'b0000001);
    wait_e(33); check("t1_d3_AN", AN, 8'hF7);
                check("t1_d3_SEG", seg, 7'b0000110);

    value_in = 32'h0000_00A0; lz_blank = 1'b1;
    wait_pos(1);
    wait_pos(13); check("t2_d1_AN", AN, 8'hFD);
                  check("t2_d1_SEG", seg, 7'b0001000);
    wait_pos(23); check("t2_d2_suppr", AN, 8'hFF);

    value_in = 32'h1111_1111; lz_blank = 1'b0;
    wait_pos(1);
    wait_pos(45); value_in = 32'h2222_2222;
    wait_pos(65); check("t3_old_AN", AN, 8'hBF);
                  check("t3_old_SEG", seg, 7'b1001111);
    wait_pos(1);
    wait_pos(65); check("t3_new_SEG", seg, 7'b0010010);

    digit_en = 8'b1010_1010; dp_in = 8'h02; value_in = $urandom;
    wait_pos(1);
    wait_pos(13); check("t4_d1_AN", AN, 8'hFD);
                  check("t4_d1_DP", DP, 1'b0);
    wait_pos(79);

    digit_en = 8'hFF; dp_in = 8'h00; value_in = 32'h5555_5555;
    wait_pos(1);
    wait_pos(55);
    mid_reset();
    wait_e(1); check("t5_fs_after", frame_start, 1'b1);
    wait_e(3); check("t5_d0_AN", AN, 8'hFE);
               check("t5_d0_SEG", seg, 7'b0100100);

    value_in = 32'hFEDC_BA98;
    wait_pos(1);
    wait_pos(73); check("t6_d7_AN", AN, 8'h7F);
                  check("t6_d7_SEG", seg, 7'b0111000);
    wait_pos(79);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(1, 120)) @(negedge clk);
      v  = $urandom;
      sh = $urandom_range(0, 8);
      value_in = (sh == 8) ? 32'h0 : (v >> (4 * sh));
      dp_in    = 8'($urandom);
      digit_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      lz_blank = 1'($urandom_range(0, 1));
      if (i == 12) mid_reset();
    end
    wait_pos(1);
    wait_pos(79);

    check("sb_active", (n_pop >= 1000) ? 32'd1 : 32'd0, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
